// File: rtl/bt_pkg.sv
// Shared types and default command tables for the Bluetooth command sequencer.
// Optional response-timeout feature macro: BT_RESP_TMO_EN (see bt_cmd_seq).
package bt_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        PWRUP,
        BOOT,
        INIT_TX,
        INIT_WAIT,
        LISTEN,
        CMD_WAIT,
        ERR
    } state_t;

    // One entry of the snd_cmd command ROM: start address and byte length
    typedef struct packed {
        logic [4:0] start;
        logic [3:0] len;
    } cmd_t;

    // Default tables; entry 0 sits in the most significant field
    localparam logic [9:0] INIT_START_DEF = {5'd0, 5'd6};
    localparam logic [7:0] INIT_LEN_DEF   = {4'd6, 4'd10};
    localparam logic [9:0] BTN_START_DEF  = {5'd16, 5'd20};
    localparam logic [7:0] BTN_LEN_DEF    = {4'd4, 4'd4};

    // Index width that stays at least one bit for single-entry tables
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bt_req_arb.sv
// Button request arbiter: pending-request register plus lowest-index pick.
// In listen mode the picked request is consumed and the rest stay pending;
// in accumulate mode new releases OR into pending; otherwise inputs are dropped.
module bt_req_arb
    import bt_pkg::*;
#(
    parameter int NUM_BTN = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_rel,
    input  logic               listen,
    input  logic               accum,
    output logic               req_any,
    output logic [IDX_W-1:0]   pick_idx
);

    logic [NUM_BTN-1:0] pending_reg;
    logic [NUM_BTN-1:0] pending_next;
    logic [NUM_BTN-1:0] req;
    logic [NUM_BTN-1:0] onehot;
    logic [NUM_BTN:0]   below;

    assign req      = pending_reg | btn_rel;
    assign below[0] = 1'b0;
    assign req_any  = below[NUM_BTN];

    // Prefix-OR chain: a bit wins only if no lower-index request is set
    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_pick
            assign onehot[gi]    = req[gi] & ~below[gi];
            assign below[gi + 1] = below[gi] | req[gi];
        end
    endgenerate

    // Encode the one-hot winner into an index
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (onehot[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Pending update depends on what the sequencer is doing this cycle
    always_comb begin
        pending_next = pending_reg;
        if (listen) begin
            pending_next = req & ~onehot;
        end else if (accum) begin
            pending_next = req;
        end
    end

    // Pending request register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

endmodule

// File: rtl/bt_cmd_seq.sv
// Bluetooth command sequencer: power-up hold-off, boot banner wait, init
// script, then button-release to command mapping for the snd_cmd engine.
// Optional macro BT_RESP_TMO_EN adds a response timeout with retry and a
// sticky error state; without it err is tied low and waits are unbounded.
module bt_cmd_seq
    import bt_pkg::*;
#(
    parameter int NUM_BTN  = 2,
    parameter int PWRUP_W  = 17,
    parameter int NUM_INIT = 2,
    parameter logic [5*((NUM_INIT > 0) ? NUM_INIT : 1)-1:0] INIT_START = INIT_START_DEF,
    parameter logic [4*((NUM_INIT > 0) ? NUM_INIT : 1)-1:0] INIT_LEN   = INIT_LEN_DEF,
    parameter logic [5*NUM_BTN-1:0] BTN_START = BTN_START_DEF,
    parameter logic [4*NUM_BTN-1:0] BTN_LEN   = BTN_LEN_DEF,
    parameter int TMO_CYC   = 2_000_000,
    parameter int MAX_RETRY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_rel,
    input  logic               resp_rcvd,
    output logic               send,
    output logic [4:0]         cmd_start,
    output logic [3:0]         cmd_len,
    output logic               cmd_n,
    output logic               ready,
    output logic               err
);

    localparam int NI = (NUM_INIT > 0) ? NUM_INIT : 1;
    localparam int IW = idx_w(NI);
    localparam int BW = idx_w(NUM_BTN);

    state_t               state_reg, state_next;
    logic [PWRUP_W-1:0]   cnt_reg, cnt_next;
    logic [IW-1:0]        idx_reg, idx_next;
    logic                 send_reg, send_next;
    logic [4:0]           cmd_start_reg, cmd_start_next;
    logic [3:0]           cmd_len_reg, cmd_len_next;
    logic                 cmd_n_reg, cmd_n_next;
    logic                 ready_reg, ready_next;
    logic                 resp_ok;
    logic                 req_any;
    logic [BW-1:0]        pick_idx;

    cmd_t init_tbl [NI];
    cmd_t btn_tbl  [NUM_BTN];

    // Unpack the flat table parameters; entry 0 is the most significant field
    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_init_tbl
            assign init_tbl[gi].start = INIT_START[5*(NI-1-gi) +: 5];
            assign init_tbl[gi].len   = INIT_LEN[4*(NI-1-gi) +: 4];
        end
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn_tbl
            assign btn_tbl[gi].start = BTN_START[5*(NUM_BTN-1-gi) +: 5];
            assign btn_tbl[gi].len   = BTN_LEN[4*(NUM_BTN-1-gi) +: 4];
        end
    endgenerate

    // A response in the same cycle as our own send pulse is stale; drop it
    assign resp_ok = resp_rcvd && !send_reg;

    bt_req_arb #(
        .NUM_BTN (NUM_BTN),
        .IDX_W   (BW)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_rel  (btn_rel),
        .listen   (state_reg == LISTEN),
        .accum    (state_reg == CMD_WAIT),
        .req_any  (req_any),
        .pick_idx (pick_idx)
    );

`ifdef BT_RESP_TMO_EN
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [TW-1:0] tmo_reg, tmo_next;
    logic [RW-1:0] retry_reg, retry_next;
    logic          err_reg, err_next;
    logic          tmo_hit;

    assign tmo_hit = (tmo_reg == TW'(TMO_CYC - 1));
    assign err     = err_reg;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TMO_CYC[0], MAX_RETRY[0]};
    assign err        = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        send_next      = 1'b0;
        cmd_start_next = cmd_start_reg;
        cmd_len_next   = cmd_len_reg;
        cmd_n_next     = cmd_n_reg;
        ready_next     = ready_reg;
`ifdef BT_RESP_TMO_EN
        retry_next     = retry_reg;
        err_next       = err_reg;
`endif
        case (state_reg)
            PWRUP: begin
                if (&cnt_reg) begin
                    cmd_n_next = 1'b0;
                    state_next = BOOT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            BOOT: begin
                if (resp_ok) begin
                    if (NUM_INIT == 0) begin
                        ready_next = 1'b1;
                        state_next = LISTEN;
                    end else begin
                        state_next = INIT_TX;
                    end
                end
            end
            INIT_TX: begin
                send_next      = 1'b1;
                cmd_start_next = init_tbl[idx_reg].start;
                cmd_len_next   = init_tbl[idx_reg].len;
                state_next     = INIT_WAIT;
`ifdef BT_RESP_TMO_EN
                retry_next     = '0;
`endif
            end
            INIT_WAIT: begin
                if (resp_ok) begin
                    idx_next = idx_reg + 1'b1;
                    if (int'(idx_reg) + 1 == NUM_INIT) begin
                        ready_next = 1'b1;
                        state_next = LISTEN;
                    end else begin
                        state_next = INIT_TX;
                    end
                end
`ifdef BT_RESP_TMO_EN
                else if (tmo_hit) begin
                    if (int'(retry_reg) >= MAX_RETRY) begin
                        err_next   = 1'b1;
                        ready_next = 1'b0;
                        cmd_n_next = 1'b1;
                        state_next = ERR;
                    end else begin
                        send_next  = 1'b1;
                        retry_next = retry_reg + 1'b1;
                    end
                end
`endif
            end
            LISTEN: begin
                if (req_any) begin
                    send_next      = 1'b1;
                    cmd_start_next = btn_tbl[pick_idx].start;
                    cmd_len_next   = btn_tbl[pick_idx].len;
                    state_next     = CMD_WAIT;
`ifdef BT_RESP_TMO_EN
                    retry_next     = '0;
`endif
                end
            end
            CMD_WAIT: begin
                if (resp_ok) begin
                    state_next = LISTEN;
                end
`ifdef BT_RESP_TMO_EN
                else if (tmo_hit) begin
                    if (int'(retry_reg) >= MAX_RETRY) begin
                        err_next   = 1'b1;
                        ready_next = 1'b0;
                        cmd_n_next = 1'b1;
                        state_next = ERR;
                    end else begin
                        send_next  = 1'b1;
                        retry_next = retry_reg + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_next = state_reg;
            end
        endcase
    end

`ifdef BT_RESP_TMO_EN
    // Response timer: restarts on every send, runs only while waiting
    always_comb begin
        tmo_next = '0;
        if (!send_next && (state_reg == INIT_WAIT || state_reg == CMD_WAIT)) begin
            tmo_next = tmo_reg + 1'b1;
        end
    end
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= PWRUP;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            send_reg      <= 1'b0;
            cmd_start_reg <= '0;
            cmd_len_reg   <= '0;
            cmd_n_reg     <= 1'b1;
            ready_reg     <= 1'b0;
`ifdef BT_RESP_TMO_EN
            tmo_reg       <= '0;
            retry_reg     <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            send_reg      <= send_next;
            cmd_start_reg <= cmd_start_next;
            cmd_len_reg   <= cmd_len_next;
            cmd_n_reg     <= cmd_n_next;
            ready_reg     <= ready_next;
`ifdef BT_RESP_TMO_EN
            tmo_reg       <= tmo_next;
            retry_reg     <= retry_next;
            err_reg       <= err_next;
`endif
        end
    end

    assign send      = send_reg;
    assign cmd_start = cmd_start_reg;
    assign cmd_len   = cmd_len_reg;
    assign cmd_n     = cmd_n_reg;
    assign ready     = ready_reg;

endmodule
